// File: rtl/inst_loader.sv
// inst_loader: boot loader that assembles little-endian words from a byte
// stream and writes them to instruction memory while holding the core in reset.
//
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   start, len_words     : load request and word count (1..MEM_WORDS)
//   rx_data/valid/ready  : byte stream handshake
//   mem_we/addr/wdata    : instruction memory write port (word-aligned bytes)
//   cpu_rst              : active-high core reset, low only after a good load
//   busy, done, err      : status
//   csum                 : mod-2^32 sum of words written in this load
module inst_loader #(
  parameter int MEM_WORDS = 1001,
  parameter int LEN_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len_words,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             cpu_rst,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      csum
);

  // Word index must be able to count up to MEM_WORDS itself.
  localparam int IDX_W = $clog2(MEM_WORDS + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RECV  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [1:0]       bidx_q, bidx_d;
  logic [IDX_W-1:0] widx_q, widx_d;
  logic [23:0]      shift_q, shift_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      csum_q, csum_d;

  logic is_recv;
  logic is_write;
  logic is_done;
  logic is_err;
  logic is_wait;

  assign is_recv  = (state_q == S_RECV);
  assign is_write = (state_q == S_WRITE);
  assign is_done  = (state_q == S_DONE);
  assign is_err   = (state_q == S_ERR);
  assign is_wait  = (state_q == S_IDLE)
                  | is_done
                  | is_err;

  logic [31:0] len_ext;
  logic        len_ok;

  assign len_ext = 32'(len_words);
  assign len_ok  = (len_ext != 32'd0)
                 && (len_ext <= 32'(MEM_WORDS));

  logic [31:0] widx_ext;
  logic        last_word;

  assign widx_ext  = 32'(widx_q);
  assign last_word = (widx_ext + 32'd1)
                     == 32'(len_q);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    bidx_d  = bidx_q;
    widx_d  = widx_q;
    shift_d = shift_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    csum_d  = csum_q;

    unique case (1'b1)
      is_wait: begin
        if (start) begin
          if (len_ok) begin
            len_d   = len_words;
            bidx_d  = 2'd0;
            widx_d  = '0;
            shift_d = 24'd0;
            csum_d  = 32'd0;
            state_d = S_RECV;
          end else begin
            state_d = S_ERR;
          end
        end
      end

      is_recv: begin
        if (rx_valid) begin
          // Index wraps 3 -> 0, which also
          // clears it for the next word.
          bidx_d = bidx_q + 2'd1;
          unique case (bidx_q)
            2'd0: shift_d[7:0]   = rx_data;
            2'd1: shift_d[15:8]  = rx_data;
            2'd2: shift_d[23:16] = rx_data;
            default: begin
              // Latch the write now so the
              // WRITE cycle sees registered
              // address and data.
              addr_d  = widx_ext << 2;
              wdata_d = {rx_data, shift_q};
              state_d = S_WRITE;
            end
          endcase
        end
      end

      is_write: begin
        csum_d  = csum_q + wdata_q;
        widx_d  = widx_q + IDX_W'(1);
        bidx_d  = 2'd0;
        state_d = last_word ? S_DONE
                            : S_RECV;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      bidx_q  <= 2'd0;
      widx_q  <= '0;
      shift_q <= 24'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      csum_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      bidx_q  <= bidx_d;
      widx_q  <= widx_d;
      shift_q <= shift_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      csum_q  <= csum_d;
    end
  end

  // Status outputs decode the state
  // register only.
  assign rx_ready  = is_recv;
  assign mem_we    = is_write;
  assign busy      = is_recv | is_write;
  assign done      = is_done;
  assign err       = is_err;
  assign cpu_rst   = ~is_done;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign csum      = csum_q;

endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: directed + randomized bench for inst_loader.
// Reference model assembles words from the byte list arithmetically.
module tb_inst_loader;

  localparam int MW = 1001;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] len_words;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] csum;

  inst_loader #(
    .MEM_WORDS(MW),
    .LEN_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .len_words(len_words),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_rst(cpu_rst),
    .busy(busy),
    .done(done),
    .err(err),
    .csum(csum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int          c;
  } wr_t;

  wr_t wr_q[$];
  int  ready_bad = 0;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_t e;
      e.a = mem_addr;
      e.d = mem_wdata;
      e.c = cyc;
      wr_q.push_back(e);
      if (rx_ready !== 1'b0) ready_bad++;
    end
  end

  int total  = 0;
  int passed = 0;
  int failed = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  logic [7:0] bq[$];

  // Word i = sum of byte(4i+k) * 256^k.
  function automatic logic [31:0] mword(input int i);
    logic [31:0] w;
    w = 32'd0;
    for (int k = 0; k < 4; k++)
      w = w + 32'(bq[4*i+k]) * (32'd1 << (8*k));
    return w;
  endfunction

  function automatic logic [31:0] msum(input int n);
    logic [31:0] s;
    s = 32'd0;
    for (int i = 0; i < n; i++) s = s + mword(i);
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int len);
    wr_q.delete();
    ready_bad = 0;
    start     = 1'b1;
    len_words = 16'(len);
    step();
    start     = 1'b0;
  endtask

  task automatic send_bytes(input int lo,
                            input int hi,
                            input int maxgap);
    for (int i = lo; i <= hi; i++) begin
      int g;
      int t;
      g = int'($urandom_range(maxgap, 0));
      rx_valid = 1'b0;
      repeat (g) step();
      rx_valid = 1'b1;
      rx_data  = bq[i];
      t = 0;
      while (rx_ready !== 1'b1 && t < 20) begin
        step();
        t++;
      end
      if (t >= 20) begin
        chk("rx_ready_wait", 32'(rx_ready), 32'd1);
        rx_valid = 1'b0;
        return;
      end
      step();
    end
    rx_valid = 1'b0;
  endtask

  // Called in the WRITE cycle of the last word.
  task automatic finish_load(input string tag,
                             input int n);
    int bad;
    step();
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_csum"}, csum, msum(n));
    chk({tag, "_nwr"}, wr_q.size(), n);
    bad = 0;
    for (int i = 0; i < wr_q.size() && i < n; i++)
      if (wr_q[i].a !== 32'(4*i) ||
          wr_q[i].d !== mword(i)) bad++;
    chk({tag, "_wr_bad"}, bad, 0);
    chk({tag, "_rdy_in_wr"}, ready_bad, 0);
  endtask

  task automatic rand_bytes(input int n);
    bq.delete();
    for (int i = 0; i < n; i++)
      bq.push_back(8'($urandom));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] base;

    rst_n     = 1'b0;
    start     = 1'b0;
    len_words = 16'd0;
    rx_data   = 8'd0;
    rx_valid  = 1'b0;

    // 1. reset values
    repeat (3) step();
    rst_n = 1'b1;
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_csum", csum, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    rx_valid = 1'b1;
    rx_data  = 8'hAA;
    repeat (3) step();
    rx_valid = 1'b0;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_rx_ready", 32'(rx_ready), 32'd0);
    chk("idle_nwr", wr_q.size(), 0);

    // 2. basic 2-word load
    bq = '{8'h13, 8'h00, 8'h00, 8'h00,
           8'hB3, 8'h00, 8'h20, 8'h00};
    pulse_start(2);
    chk("basic_busy", 32'(busy), 32'd1);
    chk("basic_rx_ready", 32'(rx_ready), 32'd1);
    chk("basic_cpu_rst", 32'(cpu_rst), 32'd1);
    send_bytes(0, 7, 0);
    finish_load("basic", 2);
    chk("basic_csum_lit", csum, 32'h002000C6);
    if (wr_q.size() >= 2) begin
      chk("basic_w1", wr_q[1].d, 32'h002000B3);
      chk("basic_gap", wr_q[1].c - wr_q[0].c, 5);
    end
    step();
    chk("done_hold", 32'(done), 32'd1);

    // 3. gaps on the same stream, then random data
    pulse_start(2);
    send_bytes(0, 7, 3);
    finish_load("gaps", 2);
    rand_bytes(24);
    pulse_start(6);
    send_bytes(0, 23, 3);
    finish_load("rnd6", 6);

    // 4. length errors
    pulse_start(0);
    chk("len0_err", 32'(err), 32'd1);
    chk("len0_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("len0_busy", 32'(busy), 32'd0);
    chk("len0_done", 32'(done), 32'd0);
    repeat (2) step();
    chk("len0_nwr", wr_q.size(), 0);
    pulse_start(MW + 1);
    chk("len1002_err", 32'(err), 32'd1);
    chk("len1002_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("len1002_rx_ready", 32'(rx_ready), 32'd0);
    repeat (2) step();
    chk("len1002_nwr", wr_q.size(), 0);
    rand_bytes(4);
    pulse_start(1);
    chk("len1_err_clr", 32'(err), 32'd0);
    chk("len1_busy", 32'(busy), 32'd1);
    send_bytes(0, 3, 2);
    finish_load("len1", 1);

    // 5a. start during word 1 is ignored
    rand_bytes(12);
    pulse_start(3);
    send_bytes(0, 5, 1);
    start     = 1'b1;
    len_words = 16'd5;
    step();
    start     = 1'b0;
    chk("mid_start_busy", 32'(busy), 32'd1);
    send_bytes(6, 11, 1);
    finish_load("mid_start", 3);

    // 5b. reset mid-load
    rand_bytes(12);
    pulse_start(3);
    send_bytes(0, 5, 1);
    rst_n = 1'b0;
    step();
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("mid_rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("mid_rst_we", 32'(mem_we), 32'd0);
    chk("mid_rst_csum", csum, 32'd0);
    chk("mid_rst_addr", mem_addr, 32'd0);
    n = wr_q.size();
    chk("mid_rst_nwr_before", n, 1);
    rst_n = 1'b1;
    repeat (3) step();
    chk("mid_rst_nwr_after", wr_q.size(), n);
    chk("mid_rst_done", 32'(done), 32'd0);

    // 6. full depth, then reload from DONE
    bq.delete();
    base = $urandom;
    for (int i = 0; i < MW; i++) begin
      logic [31:0] w;
      w = base + 32'(i);
      for (int k = 0; k < 4; k++)
        bq.push_back(8'(w >> (8*k)));
    end
    pulse_start(MW);
    send_bytes(0, 4*MW - 1, 1);
    finish_load("full", MW);
    if (wr_q.size() > 0)
      chk("full_last_addr",
          wr_q[wr_q.size()-1].a, 32'h00000FA0);

    rand_bytes(4);
    pulse_start(1);
    chk("reload_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("reload_done", 32'(done), 32'd0);
    chk("reload_csum0", csum, 32'd0);
    send_bytes(0, 3, 0);
    finish_load("reload", 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/inst_loader.md
# inst_loader

Boot-time program loader that writes the instruction memory. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. Each word is written into consecutive word-aligned addresses of the instruction memory write port. The loader holds the CPU core in reset until the requested number of words has been written.

## Interface

**Parameters**
- MEM_WORDS, default 1001: instruction memory depth in words; the highest legal word index is MEM_WORDS-1.
- LEN_W, default 16: width of the word-count input.

**Ports**
- clk, input, 1: single clock; all state changes on the rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- start, input, 1: single-cycle load request; captures len_words.
- len_words, input, LEN_W: number of words to load; legal range 1..MEM_WORDS.
- rx_data, input, 8: incoming program byte.
- rx_valid, input, 1: rx_data is valid.
- rx_ready, output, 1: loader accepts a byte this cycle.
- mem_we, output, 1: one-cycle write strobe to instruction memory.
- mem_addr, output, 32: byte address of the write, word-aligned (bits [1:0] = 0).
- mem_wdata, output, 32: assembled instruction word.
- cpu_rst, output, 1: active-high reset to the core and instruction memory read port.
- busy, output, 1: high in RECV or WRITE.
- done, output, 1: load completed successfully.
- err, output, 1: rejected length.
- csum, output, 32: modulo-2^32 sum of all words written in the current load.

## Operation

**States**
- IDLE
- RECV
- WRITE
- DONE
- ERR

**Reset** (rst_n=0 at an edge)
- State goes to IDLE.
- cpu_rst=1; all other outputs are 0, including mem_addr, mem_wdata and csum.
- Byte index, word index and shift register are cleared.
- This applies from any state, including mid-load. No write is issued on the reset edge.

**IDLE, DONE, ERR**
- start=1 with len_words in 1..MEM_WORDS: capture the length, clear byte index, word index and csum, set cpu_rst=1, clear done and err, then go to RECV.
- start=1 with len_words=0 or len_words>MEM_WORDS: go to ERR. err=1 and cpu_rst stays 1.
- In DONE, cpu_rst=0 and done=1 are held until the next start or reset.

**RECV**
- rx_ready=1.
- A byte is accepted when rx_valid&rx_ready. Byte k (k=0..3) lands in word bits [8k+7:8k].
- Accepting byte 3 moves the state to WRITE.
- Gaps with rx_valid=0 are allowed indefinitely.

**WRITE** (exactly one cycle)
- rx_ready=0, mem_we=1.
- mem_addr = word_index×4; mem_wdata = assembled word.
- csum updates to csum+mem_wdata on the following edge.
- word_index increments.
- If this was word len_words-1, go to DONE; otherwise return to RECV with the byte index cleared.

**Other rules**
- start is ignored in RECV and WRITE.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- Arithmetic is unsigned. The word index is wide enough for MEM_WORDS, and mem_addr is the zero-extended word index shifted left by 2.

## Timing

- All outputs are registered, or decoded from the state register only. There are no combinational paths from inputs to outputs.
- start accepted at edge N: busy=1 and rx_ready=1 from cycle N+1.
- The 4th byte accepted at edge M gives mem_we=1 during cycle M+1 (the WRITE state).
- The earliest next byte acceptance is edge M+2.
- Minimum throughput is 5 cycles per word.
- For the final word, WRITE occupies cycle M+1. done=1 and cpu_rst=0 from cycle M+2, and csum is final at the same point.
- A full-depth load of MEM_WORDS=1001 words ends with its last write at mem_addr 0x00000FA0.

## Test plan

1. **Reset values.** Hold rst_n=0 for 3 cycles, then release. Require cpu_rst=1, rx_ready=0, mem_we=0, done=0, err=0, csum=0 and state IDLE. start stays ignored until it is pulsed.
2. **Basic 2-word load.** start with len_words=2, then bytes 13 00 00 00 B3 00 20 00 back-to-back. Require:
   - mem_we pulses exactly twice: addr 0x0 / data 0x00000013, then addr 0x4 / data 0x002000B3.
   - The pulses are 5 cycles apart.
   - done=1, cpu_rst=0 and csum=0x002000C6 two cycles after the last byte is accepted.
3. **Backpressure and gaps.** The same stream with random 0–3 cycle rx_valid gaps. Require identical writes and csum, no duplicated or dropped bytes, and rx_ready=0 in every WRITE cycle.
4. **Length errors.**
   - len_words=0: err=1 next cycle, cpu_rst=1, no mem_we.
   - Then len_words=1002: same result.
   - Then len_words=1 with valid bytes: err clears, the load completes and done=1.
5. **Mid-load events.**
   - During word 1 of a 3-word load, pulse start with len_words=5: it is ignored and the load finishes after 3 words.
   - Repeat the load and drive rst_n=0 after 2 bytes of word 1: IDLE, cpu_rst=1, no mem_we on or after the reset edge.
6. **Full depth and reload.**
   - Load 1001 incrementing words: the last write is at addr 0xFA0 and csum equals the software sum.
   - Then start a 1-word load from DONE: cpu_rst reasserts the cycle after start, and csum restarts from 0.
